// File: rtl/double_pkg.sv
// Shared binary64 operand definitions: class codes, exponent constants and the
// handshake FSM state encoding used by the unpack stage and downstream units.
package double_pkg;

  localparam int EXP_W = 13;
  localparam int MAN_W = 53;

  localparam logic [EXP_W-1:0] BIAS        = 13'd1023;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 13'd1024;
  localparam logic [EXP_W-1:0] EXP_ZERO    = 13'h1C01;  // -1023
  localparam logic [EXP_W-1:0] EXP_DENORM  = 13'h1C02;  // -1022

  typedef enum logic [2:0] {
    CLS_NORMAL   = 3'd0,
    CLS_DENORMAL = 3'd1,
    CLS_ZERO     = 3'd2,
    CLS_INF      = 3'd3,
    CLS_QNAN     = 3'd4,
    CLS_SNAN     = 3'd5
  } class_t;

  typedef enum logic [1:0] {
    GET_A     = 2'd0,
    UNPACK    = 2'd1,
    NORMALISE = 2'd2,
    PUT_Z     = 2'd3
  } state_t;

endpackage

// File: rtl/double_classify.sv
// Combinational decode of a binary64 exponent/fraction pair into class code,
// starting unbiased exponent and significand with the hidden bit explicit.
module double_classify
  import double_pkg::*;
#(
  parameter bit FLUSH_DENORMAL = 1'b0
) (
  input  logic [10:0]       e,
  input  logic [51:0]       f,
  output logic [2:0]        cls,
  output logic [EXP_W-1:0]  exp,
  output logic [MAN_W-1:0]  man
);

  always_comb begin
    cls = CLS_NORMAL;
    exp = {2'b00, e} - BIAS;
    man = {1'b1, f};
    if (e == 11'h7FF) begin
      // NaN payloads pass through untouched; signalling NaNs are not quietened
      exp = EXP_SPECIAL;
      man = {1'b1, f};
      if (f == 52'd0)
        cls = CLS_INF;
      else if (f[51])
        cls = CLS_QNAN;
      else
        cls = CLS_SNAN;
    end else if (e == 11'd0) begin
      if (f == 52'd0 || FLUSH_DENORMAL) begin
        cls = CLS_ZERO;
        exp = EXP_ZERO;
        man = '0;
      end else begin
        cls = CLS_DENORMAL;
        exp = EXP_DENORM;
        man = {1'b0, f};
      end
    end
  end

endmodule

// File: rtl/double_unpack.sv
// Binary64 operand unpack stage: accepts a word over stb/ack, splits and
// classifies it, normalises denormals one bit per cycle, then presents it.
module double_unpack
  import double_pkg::*;
#(
  parameter bit FLUSH_DENORMAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       input_a,
  input  logic              input_a_stb,
  output logic              input_a_ack,
  output logic              output_z_sign,
  output logic [EXP_W-1:0]  output_z_exp,
  output logic [MAN_W-1:0]  output_z_man,
  output logic [2:0]        output_z_class,
  output logic              output_z_stb,
  input  logic              output_z_ack
);

  state_t            state, next_state;
  logic [63:0]       a_reg, next_a;
  logic              next_ack, next_stb, next_sign;
  logic [EXP_W-1:0]  next_exp, c_exp;
  logic [MAN_W-1:0]  next_man, c_man;
  logic [2:0]        next_class, c_class;

  double_classify #(
    .FLUSH_DENORMAL(FLUSH_DENORMAL)
  ) u_classify (
    .e   (a_reg[62:52]),
    .f   (a_reg[51:0]),
    .cls (c_class),
    .exp (c_exp),
    .man (c_man)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= GET_A;
      a_reg          <= '0;
      input_a_ack    <= 1'b0;
      output_z_stb   <= 1'b0;
      output_z_sign  <= 1'b0;
      output_z_exp   <= '0;
      output_z_man   <= '0;
      output_z_class <= '0;
    end else begin
      state          <= next_state;
      a_reg          <= next_a;
      input_a_ack    <= next_ack;
      output_z_stb   <= next_stb;
      output_z_sign  <= next_sign;
      output_z_exp   <= next_exp;
      output_z_man   <= next_man;
      output_z_class <= next_class;
    end
  end

  always_comb begin
    next_state = state;
    next_a     = a_reg;
    next_ack   = input_a_ack;
    next_stb   = output_z_stb;
    next_sign  = output_z_sign;
    next_exp   = output_z_exp;
    next_man   = output_z_man;
    next_class = output_z_class;
    case (state)
      GET_A: begin
        next_ack = 1'b1;
        if (input_a_stb && input_a_ack) begin
          next_a     = input_a;
          next_ack   = 1'b0;
          next_state = UNPACK;
        end
      end
      UNPACK: begin
        next_sign  = a_reg[63];
        next_exp   = c_exp;
        next_man   = c_man;
        next_class = c_class;
        next_state = (c_class == CLS_DENORMAL) ? NORMALISE : PUT_Z;
      end
      NORMALISE: begin
        // Raising stb on the detecting edge keeps denormal latency at 2+shifts
        if (output_z_man[MAN_W-1]) begin
          next_stb   = 1'b1;
          next_state = PUT_Z;
        end else begin
          next_man = output_z_man << 1;
          next_exp = output_z_exp - 13'd1;
        end
      end
      PUT_Z: begin
        if (output_z_stb && output_z_ack) begin
          next_stb   = 1'b0;
          next_state = GET_A;
        end else begin
          next_stb = 1'b1;
        end
      end
      default: next_state = GET_A;
    endcase
  end

endmodule

// File: tb/tb_double_unpack.sv
// Self-checking bench for double_unpack: directed vectors, backpressure, reset
// abort and randomized operands against a behavioural binary64 decode model.
module tb_double_unpack;

  typedef struct {
    logic        sign;
    logic [12:0] exp;
    logic [52:0] man;
    logic [2:0]  cls;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a_in [2];
  logic        a_stb [2];
  logic        a_ack [2];
  logic        z_sign [2];
  logic [12:0] z_exp [2];
  logic [52:0] z_man [2];
  logic [2:0]  z_class [2];
  logic        z_stb [2];
  logic        z_ack [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  double_unpack #(.FLUSH_DENORMAL(1'b0)) dut (
    .clk(clk), .rst(rst),
    .input_a(a_in[0]), .input_a_stb(a_stb[0]), .input_a_ack(a_ack[0]),
    .output_z_sign(z_sign[0]), .output_z_exp(z_exp[0]), .output_z_man(z_man[0]),
    .output_z_class(z_class[0]), .output_z_stb(z_stb[0]), .output_z_ack(z_ack[0])
  );

  double_unpack #(.FLUSH_DENORMAL(1'b1)) dut_flush (
    .clk(clk), .rst(rst),
    .input_a(a_in[1]), .input_a_stb(a_stb[1]), .input_a_ack(a_ack[1]),
    .output_z_sign(z_sign[1]), .output_z_exp(z_exp[1]), .output_z_man(z_man[1]),
    .output_z_class(z_class[1]), .output_z_stb(z_stb[1]), .output_z_ack(z_ack[1])
  );

  // Reference decode straight from the binary64 encoding rules
  function automatic exp_t model(input logic [63:0] a, input bit flush);
    exp_t        r;
    int          e;
    int          k;
    logic [51:0] f;
    e = int'(a[62:52]);
    f = a[51:0];
    r.sign = a[63];
    r.lat  = 2;
    if (e == 2047) begin
      r.exp = 13'd1024;
      r.man = {1'b1, f};
      r.cls = (f == 0) ? 3'd3 : (f[51] ? 3'd4 : 3'd5);
    end else if (e == 0 && (f == 0 || flush)) begin
      r.exp = 13'(-1023);
      r.man = '0;
      r.cls = 3'd2;
    end else if (e == 0) begin
      k = 0;
      for (int i = 0; i < 52; i++) if (f[i]) k = i;
      r.man = 53'(f) << (52 - k);
      r.exp = 13'(-1022 - (52 - k));
      r.cls = 3'd1;
      r.lat = 2 + 52 - k;
    end else begin
      r.exp = 13'(e - 1023);
      r.man = {1'b1, f};
      r.cls = 3'd0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Waits for ack, hands over one operand and returns edges until stb is seen
  task automatic applyStimulus(input int sel, input logic [63:0] a, output int lat);
    int waited = 0;
    while (a_ack[sel] !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ack_ready", 64'(a_ack[sel]), 64'd1);
    @(negedge clk);
    a_in[sel]  = a;
    a_stb[sel] = 1'b1;
    @(posedge clk);
    #1;
    a_stb[sel] = 1'b0;
    lat = 0;
    while (lat < 80) begin
      @(posedge clk);
      lat++;
      #1;
      if (z_stb[sel] === 1'b1) break;
    end
  endtask

  task automatic checkOutput(input int sel, input string tag, input exp_t r, input int lat);
    chk({tag, "_latency"}, 64'(lat), 64'(r.lat));
    chk({tag, "_sign"}, 64'(z_sign[sel]), 64'(r.sign));
    chk({tag, "_exp"}, 64'(z_exp[sel]), 64'(r.exp));
    chk({tag, "_man"}, 64'(z_man[sel]), 64'(r.man));
    chk({tag, "_class"}, 64'(z_class[sel]), 64'(r.cls));
  endtask

  // With z_ack high the transfer happens on the next edge, ack returns one later
  task automatic finishItem(input int sel, input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_stb_drop"}, 64'(z_stb[sel]), 64'd0);
    chk({tag, "_ack_low"}, 64'(a_ack[sel]), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_ack_back"}, 64'(a_ack[sel]), 64'd1);
  endtask

  task automatic runItem(input int sel, input string tag, input logic [63:0] a);
    int lat;
    applyStimulus(sel, a, lat);
    checkOutput(sel, tag, model(a, sel == 1), lat);
    finishItem(sel, tag);
  endtask

  function automatic logic [63:0] randomOperand();
    logic [63:0] v;
    logic [51:0] f;
    int          kind;
    kind = $urandom_range(0, 5);
    f = {$urandom(), $urandom()};
    v[63] = 1'($urandom_range(0, 1));
    case (kind)
      0: begin v[62:52] = 11'($urandom_range(1, 2046)); v[51:0] = f; end
      1: begin v[62:52] = 11'd0; v[51:0] = 52'd0; end
      2: begin
        v[62:52] = 11'd0;
        v[51:0]  = (f >> $urandom_range(0, 51)) | 52'd1 << $urandom_range(0, 3);
      end
      3: begin v[62:52] = 11'h7FF; v[51:0] = 52'd0; end
      4: begin v[62:52] = 11'h7FF; v[51:0] = f | (52'd1 << 51); end
      default: begin
        v[62:52] = 11'h7FF;
        v[51:0]  = (f & ~(52'd1 << 51)) | 52'd1;
      end
    endcase
    return v;
  endfunction

  initial begin
    int   lat;
    exp_t r;
    logic [63:0] v;
    for (int s = 0; s < 2; s++) begin
      a_in[s] = '0; a_stb[s] = 1'b0; z_ack[s] = 1'b1;
    end
    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(a_ack[0]), 64'd0);
    chk("rst_stb", 64'(z_stb[0]), 64'd0);
    chk("rst_exp", 64'(z_exp[0]), 64'd0);
    chk("rst_man", 64'(z_man[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ack_rise", 64'(a_ack[0]), 64'd1);

    $display("[TB] directed vectors");
    runItem(0, "one", 64'h3FF0000000000000);
    runItem(0, "neg2p5", 64'hC004000000000000);
    runItem(0, "den_min", 64'h0000000000000001);
    runItem(0, "den_top", 64'h0008000000000000);
    runItem(0, "inf", 64'h7FF0000000000000);
    runItem(0, "qnan", 64'h7FF8000000000000);
    runItem(0, "snan", 64'h7FF0000000000001);
    runItem(0, "negzero", 64'h8000000000000000);

    $display("[TB] backpressure");
    z_ack[0] = 1'b0;
    v = 64'h400921FB54442D18;
    r = model(v, 1'b0);
    applyStimulus(0, v, lat);
    checkOutput(0, "bp", r, lat);
    @(negedge clk);
    a_in[0]  = 64'h3FF0000000000000;
    a_stb[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_stb", 64'(z_stb[0]), 64'd1);
      chk("bp_hold_man", 64'(z_man[0]), 64'(r.man));
      chk("bp_hold_exp", 64'(z_exp[0]), 64'(r.exp));
      chk("bp_hold_ack", 64'(a_ack[0]), 64'd0);
    end
    @(negedge clk);
    a_stb[0] = 1'b0;
    z_ack[0] = 1'b1;
    finishItem(0, "bp_release");
    @(posedge clk);
    #1;
    chk("bp_single", 64'(z_stb[0]), 64'd0);

    $display("[TB] reset during normalise");
    @(negedge clk);
    a_in[0]  = 64'h0000000000000001;
    a_stb[0] = 1'b1;
    @(posedge clk);
    #1;
    a_stb[0] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_stb", 64'(z_stb[0]), 64'd0);
    chk("abort_man", 64'(z_man[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ack", 64'(a_ack[0]), 64'd1);
    chk("abort_stb_low", 64'(z_stb[0]), 64'd0);
    runItem(0, "after_abort", 64'hC004000000000000);

    $display("[TB] flush denormal instance");
    runItem(1, "flush_den", 64'h8000000000000001);
    runItem(1, "flush_one", 64'h3FF0000000000000);

    $display("[TB] random operands");
    for (int i = 0; i < 40; i++) begin
      runItem(i % 4 == 3 ? 1 : 0, "rand", randomOperand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
